// File: rtl/baccarat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baccarat_pkg
// Description : Shared types and helpers for the Punto Banco table: FSM state
//               encoding, card valuation, dealer third-card rule and the
//               mod-10 reduction used by hand scoring.
// Revision    : 1.0 - initial release
// ============================================================================
package baccarat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_P1    = 4'd1,
        ST_D1    = 4'd2,
        ST_P2    = 4'd3,
        ST_D2    = 4'd4,
        ST_EVAL  = 4'd5,
        ST_P3    = 4'd6,
        ST_EVAL3 = 4'd7,
        ST_D3    = 4'd8,
        ST_DONE  = 4'd9
    } state_t;

    // A two-card total of 8 or 9 ends the round immediately.
    localparam logic [3:0] NATURAL_MIN = 4'd8;
    // Highest two-card score on which a hand takes a third card.
    localparam logic [3:0] DRAW_MAX    = 4'd5;

    // Ranks 1-9 count face value; tens, court cards, 0 and unused codes count 0.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return ((rank >= 4'd1) && (rank <= 4'd9)) ? rank : 4'd0;
    endfunction

    // Reduce a raw total (at most 27) to 0-9 without a divider.
    function automatic logic [3:0] mod10_sum(input logic [4:0] sum);
        logic [4:0] r;
        if (sum >= 5'd20)
            r = sum - 5'd20;
        else if (sum >= 5'd10)
            r = sum - 5'd10;
        else
            r = sum;
        return r[3:0];
    endfunction

    // Dealer third-card decision once the player has drawn card value v.
    function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] v);
        logic draw;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baccarat_table_hand_score.sv
`default_nettype none
// ============================================================================
// Module      : hand_score
// Description : Combinational baccarat hand score from up to three card ranks.
//               Undealt slots hold rank 0 and therefore add nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module hand_score
    import baccarat_pkg::*;
(
    input  logic [3:0] i_card1,
    input  logic [3:0] i_card2,
    input  logic [3:0] i_card3,
    output logic [3:0] o_score
);

    logic [4:0] w_sum;

    // Sum card values in 5 bits, then fold into 0-9.
    always_comb begin
        w_sum   = {1'b0, card_value(i_card1)}
                + {1'b0, card_value(i_card2)}
                + {1'b0, card_value(i_card3)};
        o_score = mod10_sum(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/baccarat_table.sv
`default_nettype none
// ============================================================================
// Module      : baccarat_table
// Description : Punto Banco round controller. Samples the dealer card stream
//               on step pulses, applies third-card rules, scores both hands
//               and registers the round result.
// Revision    : 1.0 - initial release
// ============================================================================
module baccarat_table
    import baccarat_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] new_card,
    input  logic       start,
    input  logic       step,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_pcard1, r_pcard2, r_pcard3;
    logic [3:0] r_dcard1, r_dcard2, r_dcard3;
    logic       r_player_win, r_dealer_win, r_done;

    logic [3:0] w_pscore, w_dscore, w_dscore_final;
    logic       w_clear, w_finish;
    logic       w_ld_p1, w_ld_p2, w_ld_p3, w_ld_d1, w_ld_d2, w_ld_d3;

    hand_score u_player_score (
        .i_card1 (r_pcard1),
        .i_card2 (r_pcard2),
        .i_card3 (r_pcard3),
        .o_score (w_pscore)
    );

    hand_score u_dealer_score (
        .i_card1 (r_dcard1),
        .i_card2 (r_dcard2),
        .i_card3 (r_dcard3),
        .o_score (w_dscore)
    );

    // Result is latched on the same edge that captures dcard3, so fold the
    // incoming card into the dealer score when finishing from D3.
    always_comb begin
        w_dscore_final = w_dscore;
        if (r_state == ST_D3)
            w_dscore_final = mod10_sum({1'b0, w_dscore} + {1'b0, card_value(new_card)});
    end

    // Next-state decode plus per-slot load strobes.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_finish     = 1'b0;
        w_ld_p1      = 1'b0;
        w_ld_p2      = 1'b0;
        w_ld_p3      = 1'b0;
        w_ld_d1      = 1'b0;
        w_ld_d2      = 1'b0;
        w_ld_d3      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_P1;
                end
            end
            ST_P1: if (step) begin w_ld_p1 = 1'b1; w_state_next = ST_D1; end
            ST_D1: if (step) begin w_ld_d1 = 1'b1; w_state_next = ST_P2; end
            ST_P2: if (step) begin w_ld_p2 = 1'b1; w_state_next = ST_D2; end
            ST_D2: if (step) begin w_ld_d2 = 1'b1; w_state_next = ST_EVAL; end
            ST_EVAL: begin
                if ((w_pscore >= NATURAL_MIN) || (w_dscore >= NATURAL_MIN)) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_pscore <= DRAW_MAX) begin
                    w_state_next = ST_P3;
                end else if (w_dscore <= DRAW_MAX) begin
                    w_state_next = ST_D3;
                end else begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_P3: if (step) begin w_ld_p3 = 1'b1; w_state_next = ST_EVAL3; end
            ST_EVAL3: begin
                if (dealer_draws(w_dscore, card_value(r_pcard3))) begin
                    w_state_next = ST_D3;
                end else begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_D3: begin
                if (step) begin
                    w_ld_d3      = 1'b1;
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Card slot registers; cleared by reset or a new round.
    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_pcard1 <= 4'd0;
            r_pcard2 <= 4'd0;
            r_pcard3 <= 4'd0;
            r_dcard1 <= 4'd0;
            r_dcard2 <= 4'd0;
            r_dcard3 <= 4'd0;
        end else begin
            if (w_ld_p1) r_pcard1 <= new_card;
            if (w_ld_p2) r_pcard2 <= new_card;
            if (w_ld_p3) r_pcard3 <= new_card;
            if (w_ld_d1) r_dcard1 <= new_card;
            if (w_ld_d2) r_dcard2 <= new_card;
            if (w_ld_d3) r_dcard3 <= new_card;
        end
    end

    // Result flags, set on entry to DONE and held until the next round.
    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_finish) begin
            r_player_win <= (w_pscore >= w_dscore_final);
            r_dealer_win <= (w_dscore_final >= w_pscore);
            r_done       <= 1'b1;
        end
    end

    assign pcard1     = r_pcard1;
    assign pcard2     = r_pcard2;
    assign pcard3     = r_pcard3;
    assign dcard1     = r_dcard1;
    assign dcard2     = r_dcard2;
    assign dcard3     = r_dcard3;
    assign pscore     = w_pscore;
    assign dscore     = w_dscore;
    assign player_win = r_player_win;
    assign dealer_win = r_dealer_win;
    assign done       = r_done;

endmodule
`default_nettype wire
